// File: rtl/lms2rgb_pkg.sv
// ============================================================================
// Module   : lms2rgb_pkg
// Brief    : Shared widths, Q4.12 LMS->RGB coefficients and FSM states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lms2rgb_pkg;

    localparam int c_IN_W    = 16;
    localparam int c_COEF_W  = 16;
    localparam int c_ACC_W   = 35;
    localparam int c_SHIFT   = 20;
    localparam int c_PROD_W  = c_IN_W + 1 + c_COEF_W;

    localparam logic signed [c_ACC_W-1:0] c_ROUND_HALF = 35'sd524288;

    localparam logic signed [c_COEF_W-1:0] c_COEF_RL =  16'sd18301;
    localparam logic signed [c_COEF_W-1:0] c_COEF_RM = -16'sd14694;
    localparam logic signed [c_COEF_W-1:0] c_COEF_RS =  16'sd489;
    localparam logic signed [c_COEF_W-1:0] c_COEF_GL = -16'sd4991;
    localparam logic signed [c_COEF_W-1:0] c_COEF_GM =  16'sd9752;
    localparam logic signed [c_COEF_W-1:0] c_COEF_GS = -16'sd665;
    localparam logic signed [c_COEF_W-1:0] c_COEF_BL =  16'sd204;
    localparam logic signed [c_COEF_W-1:0] c_COEF_BM = -16'sd999;
    localparam logic signed [c_COEF_W-1:0] c_COEF_BS =  16'sd4934;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Row-major matrix walk: k = 3*channel + {L,M,S}
    function automatic logic signed [c_COEF_W-1:0] coef_at(input logic [3:0] k);
        logic signed [c_COEF_W-1:0] c;
        c = '0;
        case (k)
            4'd0: c = c_COEF_RL;
            4'd1: c = c_COEF_RM;
            4'd2: c = c_COEF_RS;
            4'd3: c = c_COEF_GL;
            4'd4: c = c_COEF_GM;
            4'd5: c = c_COEF_GS;
            4'd6: c = c_COEF_BL;
            4'd7: c = c_COEF_BM;
            4'd8: c = c_COEF_BS;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lms2rgb_mac.sv
// ============================================================================
// Module   : lms2rgb_mac
// Brief    : Signed multiply-accumulate with shift/clamp to 8-bit channel.
//            LMS2RGB_ROUND_EN selects round-half-up instead of truncation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lms2rgb_mac
    import lms2rgb_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_clr,
    input  logic                        i_en,
    input  logic                        i_last,
    input  logic [c_IN_W-1:0]           i_data,
    input  logic signed [c_COEF_W-1:0]  i_coef,
    output logic [7:0]                  o_chan
);

    logic signed [c_ACC_W-1:0]  r_acc;
    logic signed [c_IN_W:0]     w_data_s;
    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [c_ACC_W-1:0]  w_sum;
    logic signed [c_ACC_W-1:0]  w_rnd;
    logic signed [c_ACC_W-1:0]  w_shift;

    assign w_data_s = signed'({1'b0, i_data});
    assign w_prod   = c_PROD_W'(w_data_s) * c_PROD_W'(i_coef);
    assign w_sum    = r_acc + c_ACC_W'(w_prod);

`ifdef LMS2RGB_ROUND_EN
    assign w_rnd = w_sum + c_ROUND_HALF;
`else
    assign w_rnd = w_sum;
`endif

    assign w_shift = w_rnd >>> c_SHIFT;

    // Channel output reflects the sum including the current product
    always_comb begin
        o_chan = w_shift[7:0];
        if (w_shift < 35'sd0)
            o_chan = 8'd0;
        else if (w_shift > 35'sd255)
            o_chan = 8'hFF;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_acc <= '0;
        else if (i_clr)
            r_acc <= '0;
        else if (i_en)
            r_acc <= i_last ? '0 : w_sum;
    end

endmodule

`default_nettype wire

// File: rtl/lms2rgb.sv
// ============================================================================
// Module   : lms2rgb
// Brief    : LMS (8.8) to 8-bit RGB converter, one MAC per cycle, 11-cycle
//            throughput. LMS2RGB_ROUND_EN enables rounding in lms2rgb_mac.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lms2rgb
    import lms2rgb_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [c_IN_W-1:0] i_L,
    input  logic [c_IN_W-1:0] i_M,
    input  logic [c_IN_W-1:0] i_S,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [7:0]        o_R,
    output logic [7:0]        o_G,
    output logic [7:0]        o_B
);

    state_t                     r_state;
    state_t                     w_state_next;
    logic [3:0]                 r_k;
    logic [c_IN_W-1:0]          r_l;
    logic [c_IN_W-1:0]          r_m;
    logic [c_IN_W-1:0]          r_s;
    logic                       w_accept;
    logic                       w_calc;
    logic                       w_last;
    logic [c_IN_W-1:0]          w_data;
    logic signed [c_COEF_W-1:0] w_coef;
    logic [7:0]                 w_chan;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: if (i_in_valid) begin
                w_accept     = 1'b1;
                w_state_next = ST_CALC;
            end
            ST_CALC: if (r_k == 4'd8) w_state_next = ST_DONE;
            ST_DONE: if (i_out_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign o_in_ready  = (r_state == ST_IDLE);
    assign o_out_valid = (r_state == ST_DONE);
    assign w_calc      = (r_state == ST_CALC);
    assign w_last      = w_calc && ((r_k == 4'd2) || (r_k == 4'd5) || (r_k == 4'd8));
    assign w_coef      = coef_at(r_k);

    always_comb begin
        w_data = r_s;
        case (r_k)
            4'd0, 4'd3, 4'd6: w_data = r_l;
            4'd1, 4'd4, 4'd7: w_data = r_m;
            default:          w_data = r_s;
        endcase
    end

    lms2rgb_mac u_mac (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_accept),
        .i_en   (w_calc),
        .i_last (w_last),
        .i_data (w_data),
        .i_coef (w_coef),
        .o_chan (w_chan)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_l     <= '0;
            r_m     <= '0;
            r_s     <= '0;
            o_R     <= '0;
            o_G     <= '0;
            o_B     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_k <= '0;
                r_l <= i_L;
                r_m <= i_M;
                r_s <= i_S;
            end else if (w_calc) begin
                r_k <= (r_k == 4'd8) ? 4'd0 : r_k + 4'd1;
            end
            // Channel results land on the edge closing each row of the matrix
            if (w_calc) begin
                case (r_k)
                    4'd2:    o_R <= w_chan;
                    4'd5:    o_G <= w_chan;
                    4'd8:    o_B <= w_chan;
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lms2rgb.sv
// ============================================================================
// Module   : tb_lms2rgb
// Brief    : Scoreboard bench for lms2rgb; honours LMS2RGB_ROUND_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lms2rgb;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] L, M, S;
    logic [7:0]  R, G, B;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [23:0] sb [$];

`ifdef LMS2RGB_ROUND_EN
    localparam logic [7:0] c_B_LONLY = 8'd13;
`else
    localparam logic [7:0] c_B_LONLY = 8'd12;
`endif

    always #5 clk = ~clk;

    lms2rgb dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_L         (L),
        .i_M         (M),
        .i_S         (S),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_R         (R),
        .o_G         (G),
        .o_B         (B)
    );

    // Scoreboard: compare on every output handshake
    always @(negedge clk) begin
        if (out_valid) begin
            n_checks++;
            if (in_ready) begin
                n_fail++;
                $display("FAIL ready_valid_overlap: in_ready=%0b while out_valid=1", in_ready);
            end
        end
        if (out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got rgb=%0d,%0d,%0d with empty scoreboard", R, G, B);
            end else begin
                logic [23:0] exp_rgb;
                exp_rgb = sb.pop_front();
                if ({R, G, B} !== exp_rgb)
                begin
                    n_fail++;
                    $display("FAIL rgb_out: got %0d,%0d,%0d expected %0d,%0d,%0d",
                             R, G, B, exp_rgb[23:16], exp_rgb[15:8], exp_rgb[7:0]);
                end
            end
        end
    end

    function automatic logic [7:0] ref_chan(input int c0, input int c1, input int c2,
                                            input int l, input int m, input int s);
        longint acc;
        real    v;
        acc = longint'(l) * c0 + longint'(m) * c1 + longint'(s) * c2;
        v   = real'(acc) / 1048576.0;
`ifdef LMS2RGB_ROUND_EN
        v = v + 0.5;
`endif
        v = $floor(v);
        if (v < 0.0)   return 8'd0;
        if (v > 255.0) return 8'd255;
        return 8'(int'(v));
    endfunction

    task automatic wait_in_ready();
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL in_ready_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, guard);
        end
    endtask

    // Drives one pixel with out_ready already high; returns accept-to-valid edges
    task automatic run_pixel(input logic [15:0] l, input logic [15:0] m, input logic [15:0] s,
                             input logic [23:0] exp_rgb, output int lat);
        wait_in_ready();
        sb.push_back(exp_rgb);
        L = l; M = m; S = s;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        L = 16'h0; M = 16'h0; S = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_handshake: got in_ready=%0b out_valid=%0b expected 1/0", in_ready, out_valid);
        end
        n_checks++;
        if ({R, G, B} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %0d,%0d,%0d expected 0,0,0", R, G, B);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_grey();
        int lat;
        out_ready = 1'b1;
        run_pixel(16'hFF00, 16'hFF00, 16'hFF00, {8'd255, 8'd255, 8'd255}, lat);
        n_checks++;
        if (lat !== 9) begin
            n_fail++;
            $display("FAIL grey_latency: got %0d edges expected 9", lat);
        end
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL grey_done_one_cycle: got in_ready=%0b out_valid=%0b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_patterns();
        int lat;
        out_ready = 1'b1;
        run_pixel(16'h0000, 16'h0000, 16'h0000, 24'd0, lat);
        n_checks++;
        if (lat !== 9) begin
            n_fail++;
            $display("FAIL zero_latency: got %0d expected 9", lat);
        end
        run_pixel(16'hFF00, 16'h0000, 16'h0000, {8'd255, 8'd0, c_B_LONLY}, lat);
        n_checks++;
        if (lat !== 9) begin
            n_fail++;
            $display("FAIL lonly_latency: got %0d expected 9", lat);
        end
        run_pixel(16'h0000, 16'h6400, 16'h0000, {8'd0, 8'd238, 8'd0}, lat);
        n_checks++;
        if (lat !== 9) begin
            n_fail++;
            $display("FAIL monly_latency: got %0d expected 9", lat);
        end
    endtask

    task automatic test_random();
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            int l, m, s;
            logic [23:0] e;
            l = int'($urandom_range(0, 65535));
            m = int'($urandom_range(0, 65535));
            s = int'($urandom_range(0, 65535));
            e = {ref_chan(18301, -14694, 489, l, m, s),
                 ref_chan(-4991, 9752, -665, l, m, s),
                 ref_chan(204, -999, 4934, l, m, s)};
            run_pixel(16'(l), 16'(m), 16'(s), e, lat);
            n_checks++;
            if (lat !== 9) begin
                n_fail++;
                $display("FAIL random_latency[%0d]: got %0d expected 9", i, lat);
            end
        end
    endtask

    task automatic test_back_pressure();
        int lat;
        logic [23:0] exp_rgb;
        exp_rgb = {8'd255, 8'd0, c_B_LONLY};
        out_ready = 1'b0;
        wait_in_ready();
        sb.push_back(exp_rgb);
        L = 16'hFF00; M = 16'h0000; S = 16'h0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        // valid stays high with a different pixel; it must not be taken
        L = 16'h0000; M = 16'h6400; S = 16'h0000;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat !== 9) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d expected 9", lat);
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({R, G, B} !== exp_rgb || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got rgb=%0d,%0d,%0d v=%0b r=%0b expected %0d,%0d,%0d v=1 r=0",
                         c, R, G, B, out_valid, in_ready, exp_rgb[23:16], exp_rgb[15:8], exp_rgb[7:0]);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_release: got in_ready=%0b out_valid=%0b expected 1/0", in_ready, out_valid);
        end
        n_checks++;
        if ({R, G, B} !== exp_rgb) begin
            n_fail++;
            $display("FAIL bp_outputs_kept: got %0d,%0d,%0d expected %0d,%0d,%0d",
                     R, G, B, exp_rgb[23:16], exp_rgb[15:8], exp_rgb[7:0]);
        end
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        out_ready = 1'b1;
        wait_in_ready();
        L = 16'hFF00; M = 16'hFF00; S = 16'hFF00;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (R !== 8'd255) begin
            n_fail++;
            $display("FAIL midcalc_r_written: got %0d expected 255", R);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL midcalc_reset_handshake: got in_ready=%0b out_valid=%0b expected 1/0", in_ready, out_valid);
        end
        n_checks++;
        if ({R, G, B} !== 24'd0) begin
            n_fail++;
            $display("FAIL midcalc_reset_outputs: got %0d,%0d,%0d expected 0,0,0", R, G, B);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_pixel(16'h0000, 16'h6400, 16'h0000, {8'd0, 8'd238, 8'd0}, lat);
        n_checks++;
        if (lat !== 9) begin
            n_fail++;
            $display("FAIL post_reset_latency: got %0d expected 9", lat);
        end
    endtask

    initial begin
        test_reset();
        test_grey();
        test_patterns();
        test_random();
        test_back_pressure();
        test_reset_mid_calc();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
